collision_frame_ctrl: RTL and testbench
=======================================

Name: collision_frame_ctrl

Overview:
- Per-frame collision event scheduler between the VGA scan/pixel logic and the ball motion logic.
- Samples the four pixel-coincidence collision strobes on clk and accumulates them as sticky flags during the visible frame.
- At each frame boundary, and only every Nth frame per the speed setting, issues one motion-update packet to the ball block with a valid/ready handshake.
- Replaces per-pixel combinational collision feeding with a frame-coherent, rate-controlled update.

Parameters:
- FRAME_END_LINE, 480, v_cnt value that marks the frame boundary.
- OVR_W, 8, width of the saturating overrun counter.

Ports:
- clk  in  1  system clock; all logic is on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- h_cnt  in  10  VGA horizontal counter; changes slower than clk.
- v_cnt  in  10  VGA vertical counter.
- col_x1  in  1  ball left-edge coincidence strobe.
- col_x2  in  1  ball right-edge coincidence strobe.
- col_y1  in  1  ball top-edge coincidence strobe.
- col_y2  in  1  ball bottom-edge coincidence strobe.
- enable  in  1  game in play state; when 0, accumulation and issue are suppressed.
- speed  in  2  frames per update minus 1 (0 → every frame, 3 → every 4th frame).
- upd_ready  in  1  ball block accepts the packet.
- upd_valid  out  1  packet valid.
- bounce_x  out  2  {force +x, force -x}.
- bounce_y  out  2  {force +y, force -y}.
- frame_tick  out  1  one-clk pulse at each detected frame boundary.
- overrun_cnt  out  OVR_W  saturating count of packets merged because ready was late.

Behaviour:
- Reset (rst=0, asynchronous): all outputs 0, sticky flags 0, frame divider 0, state ACCUM.
- Boundary detect:
  - cond = (v_cnt==FRAME_END_LINE && h_cnt==0), registered each clk.
  - frame_tick = cond & ~cond_q, so there is exactly one pulse per frame even though cond persists for several clks.
- Accumulate:
  - Sticky sx1/sx2/sy1/sy2 are set when the matching col_* is 1 and enable=1.
  - A strobe in the same clk as frame_tick is included in the closing frame.
- Direction mapping (captured flags):
  - sx1 only → bounce_x=10; sx2 only → 01; both or neither → 00.
  - sy1 only → bounce_y=10; sy2 only → 01; both or neither → 00.
- Frame divider:
  - div counts frame_ticks 0..speed.
  - A frame_tick with div==speed is an issue frame and resets div to 0; other ticks increment div.
  - If speed changes, div is compared against the new value; if div>speed, the next tick is treated as an issue frame.
- Sticky flags clear on every frame_tick. On non-issue frames they are discarded.
- FSM:
  - ACCUM: on issue frame, load packet regs from sticky flags (plus the same-clk strobes) and go to ISSUE.
  - ISSUE: upd_valid=1 and packet held stable. When upd_ready=1, the transfer happens that clk: next clk upd_valid=0 and state → ACCUM.
  - ISSUE with a new issue frame before ready (overrun): OR the new flags into the held packet, re-apply the mapping to the merged flags, overrun_cnt+1 (saturates at all-ones), stay in ISSUE.
  - ISSUE with upd_ready=1 and an issue frame in the same clk: the old packet transfers, the new packet loads, and the FSM stays in ISSUE with upd_valid=1.
- enable=0:
  - Sticky flags are held at 0 and no new issue occurs (div is frozen).
  - A packet already in ISSUE still completes its handshake.
- Latency: frame boundary clk → upd_valid high on the next clk.
- upd_valid never drops without upd_ready, and bounce_* never change while upd_valid=1 except on overrun merge.

Test Plan:
- Reset: hold rst=0 mid-ISSUE, release → upd_valid=0, bounce_x=00, bounce_y=00, overrun_cnt=0; packet discarded.
- speed=0, pulse col_x1 at v_cnt=200, ready tied 1 → one clk after frame_tick: upd_valid=1, bounce_x=10, bounce_y=00; upd_valid=0 the following clk.
- speed=2, col_y2 in frame 1 only, ready=1 → no packet at frames 1–2; packet at frame 3 with bounce_y=00 (frame-1 flag discarded); with col_y2 in frame 3 → bounce_y=01.
- Overrun: ready=0 across two issue frames (col_x2, then col_y1) → bounce_x=01, bounce_y=10, overrun_cnt=1; ready=1 → single transfer.
- Simultaneous col_x1 and col_x2 → bounce_x=00; col_y1 on the same clk as frame_tick → included, bounce_y=10.
- h_cnt held at 0 for 4 clks at v_cnt=480 → exactly one frame_tick; enable=0 → no upd_valid across 3 frames.

Source files
------------

// File: rtl/collision_frame_ctrl.sv
// Frame-coherent collision scheduler: accumulates pixel collision strobes over a frame and
// issues a rate-divided motion-update packet to the ball block over a valid/ready handshake.
module collision_frame_ctrl #(
  parameter int unsigned FRAME_END_LINE = 480,
  parameter int unsigned OVR_W          = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [9:0]       h_cnt,
  input  logic [9:0]       v_cnt,
  input  logic             col_x1,
  input  logic             col_x2,
  input  logic             col_y1,
  input  logic             col_y2,
  input  logic             enable,
  input  logic [1:0]       speed,
  input  logic             upd_ready,
  output logic             upd_valid,
  output logic [1:0]       bounce_x,
  output logic [1:0]       bounce_y,
  output logic             frame_tick,
  output logic [OVR_W-1:0] overrun_cnt
);

  typedef enum logic [0:0] {StAccum, StIssue} state_e;

  state_e           state_q, state_d;
  logic             cond, cond_q;
  logic [3:0]       sticky_q, sticky_d;  // {x1, x2, y1, y2}
  logic [3:0]       pkt_q, pkt_d;
  logic [1:0]       div_q, div_d;
  logic [OVR_W-1:0] ovr_q, ovr_d;
  logic [3:0]       col_v;
  logic [3:0]       flags;
  logic             tick_en;
  logic             issue;

  assign cond       = (v_cnt == 10'(FRAME_END_LINE)) && (h_cnt == 10'd0);
  assign frame_tick = cond & ~cond_q;

  assign col_v   = {col_x1, col_x2, col_y1, col_y2} & {4{enable}};
  // Same-clk strobes belong to the frame that is closing.
  assign flags   = sticky_q | col_v;
  assign tick_en = frame_tick & enable;
  // ">=" so a speed reduction below the current count issues on the next tick.
  assign issue   = tick_en & (div_q >= speed);

  always_comb begin
    sticky_d = flags;
    if (frame_tick || !enable) begin
      sticky_d = 4'b0000;
    end

    div_d = div_q;
    if (tick_en) begin
      div_d = issue ? 2'd0 : div_q + 2'd1;
    end
  end

  always_comb begin
    state_d = state_q;
    pkt_d   = pkt_q;
    ovr_d   = ovr_q;
    unique case (state_q)
      StAccum: begin
        if (issue) begin
          pkt_d   = flags;
          state_d = StIssue;
        end
      end
      StIssue: begin
        if (issue && upd_ready) begin
          pkt_d = flags;
        end else if (issue) begin
          pkt_d = pkt_q | flags;
          if (ovr_q != {OVR_W{1'b1}}) begin
            ovr_d = ovr_q + 1'b1;
          end
        end else if (upd_ready) begin
          state_d = StAccum;
        end
      end
      default: state_d = StAccum;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StAccum;
      cond_q   <= 1'b0;
      sticky_q <= 4'b0000;
      pkt_q    <= 4'b0000;
      div_q    <= 2'd0;
      ovr_q    <= '0;
    end else begin
      state_q  <= state_d;
      cond_q   <= cond;
      sticky_q <= sticky_d;
      pkt_q    <= pkt_d;
      div_q    <= div_d;
      ovr_q    <= ovr_d;
    end
  end

  assign upd_valid   = (state_q == StIssue);
  assign bounce_x    = {pkt_q[3] & ~pkt_q[2], pkt_q[2] & ~pkt_q[3]};
  assign bounce_y    = {pkt_q[1] & ~pkt_q[0], pkt_q[0] & ~pkt_q[1]};
  assign overrun_cnt = ovr_q;

endmodule

// File: tb/tb_collision_frame_ctrl.sv
// Directed bench for collision_frame_ctrl: inputs change on the falling edge, outputs are
// sampled on the falling edge (registered) or #1 after an input change (frame_tick).
module tb_collision_frame_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] h_cnt, v_cnt;
  logic       col_x1, col_x2, col_y1, col_y2;
  logic       enable;
  logic [1:0] speed;
  logic       upd_ready;
  logic       upd_valid;
  logic [1:0] bounce_x, bounce_y;
  logic       frame_tick;
  logic [7:0] overrun_cnt;

  int vec_cnt = 0;
  int err_cnt = 0;
  logic tick_seen;

  always #5 clk = ~clk;

  collision_frame_ctrl #(
    .FRAME_END_LINE(480),
    .OVR_W         (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .h_cnt      (h_cnt),
    .v_cnt      (v_cnt),
    .col_x1     (col_x1),
    .col_x2     (col_x2),
    .col_y1     (col_y1),
    .col_y2     (col_y2),
    .enable     (enable),
    .speed      (speed),
    .upd_ready  (upd_ready),
    .upd_valid  (upd_valid),
    .bounce_x   (bounce_x),
    .bounce_y   (bounce_y),
    .frame_tick (frame_tick),
    .overrun_cnt(overrun_cnt)
  );

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Drives one mid-frame clk with the given strobes {x1,x2,y1,y2}.
  task automatic pulse(input logic [3:0] c);
    v_cnt = 10'd200; h_cnt = 10'd17;
    {col_x1, col_x2, col_y1, col_y2} = c;
    @(negedge clk);
    {col_x1, col_x2, col_y1, col_y2} = 4'b0000;
  endtask

  // One boundary clk; records frame_tick, returns at the falling edge after the boundary edge.
  task automatic boundary();
    v_cnt = 10'd480; h_cnt = 10'd0;
    #1 tick_seen = frame_tick;
    @(negedge clk);
    v_cnt = 10'd0; h_cnt = 10'd5;
  endtask

  task automatic test_reset();
    speed = 2'd0; upd_ready = 1'b0;
    cyc(2);
    vec_cnt++;
    if (upd_valid !== 1'b0 || overrun_cnt !== 8'd0) begin
      err_cnt++;
      $display("FAIL reset_hold: valid=%b ovr=%0d, required 0/0", upd_valid, overrun_cnt);
    end
    rst = 1'b1;
    pulse(4'b1000);
    boundary();
    vec_cnt++;
    if (upd_valid !== 1'b1 || bounce_x !== 2'b10) begin
      err_cnt++;
      $display("FAIL reset_pre_issue: valid=%b bx=%b, required 1/10", upd_valid, bounce_x);
    end
    #2 rst = 1'b0;
    #1;
    vec_cnt++;
    if (upd_valid !== 1'b0 || bounce_x !== 2'b00 || bounce_y !== 2'b00 || overrun_cnt !== 8'd0)
    begin
      err_cnt++;
      $display("FAIL reset_async: valid=%b bx=%b by=%b ovr=%0d, required 0/00/00/0",
               upd_valid, bounce_x, bounce_y, overrun_cnt);
    end
    @(negedge clk);
    rst = 1'b1;
    cyc(2);
    vec_cnt++;
    if (upd_valid !== 1'b0 || bounce_x !== 2'b00) begin
      err_cnt++;
      $display("FAIL reset_release: valid=%b bx=%b, required 0/00", upd_valid, bounce_x);
    end
  endtask

  task automatic test_single();
    speed = 2'd0; upd_ready = 1'b1;
    pulse(4'b1000);
    boundary();
    vec_cnt++;
    if (tick_seen !== 1'b1) begin
      err_cnt++;
      $display("FAIL single_tick: frame_tick=%b, required 1", tick_seen);
    end
    vec_cnt++;
    if (upd_valid !== 1'b1 || bounce_x !== 2'b10 || bounce_y !== 2'b00) begin
      err_cnt++;
      $display("FAIL single_pkt: valid=%b bx=%b by=%b, required 1/10/00",
               upd_valid, bounce_x, bounce_y);
    end
    cyc(1);
    vec_cnt++;
    if (upd_valid !== 1'b0) begin
      err_cnt++;
      $display("FAIL single_drop: valid=%b, required 0", upd_valid);
    end
  endtask

  task automatic test_divider();
    logic [5:0] valid_seen;
    speed = 2'd2; upd_ready = 1'b1;
    pulse(4'b0001);
    for (int f = 0; f < 6; f++) begin
      if (f == 5) pulse(4'b0001);
      cyc(1);
      boundary();
      valid_seen[f] = upd_valid;
      if (f == 2) begin
        vec_cnt++;
        if (bounce_y !== 2'b00) begin
          err_cnt++;
          $display("FAIL div_discard: by=%b, required 00", bounce_y);
        end
      end
      if (f == 5) begin
        vec_cnt++;
        if (bounce_y !== 2'b01) begin
          err_cnt++;
          $display("FAIL div_y2: by=%b, required 01", bounce_y);
        end
      end
      cyc(1);
    end
    vec_cnt++;
    if (valid_seen !== 6'b100100) begin
      err_cnt++;
      $display("FAIL div_pattern: valid per frame=%b, required 100100", valid_seen);
    end
    speed = 2'd0;
  endtask

  task automatic test_overrun();
    speed = 2'd0; upd_ready = 1'b0;
    pulse(4'b0100);
    boundary();
    vec_cnt++;
    if (upd_valid !== 1'b1 || bounce_x !== 2'b01 || overrun_cnt !== 8'd0) begin
      err_cnt++;
      $display("FAIL ovr_first: valid=%b bx=%b ovr=%0d, required 1/01/0",
               upd_valid, bounce_x, overrun_cnt);
    end
    pulse(4'b0010);
    cyc(2);
    boundary();
    vec_cnt++;
    if (upd_valid !== 1'b1 || bounce_x !== 2'b01 || bounce_y !== 2'b10 || overrun_cnt !== 8'd1)
    begin
      err_cnt++;
      $display("FAIL ovr_merge: valid=%b bx=%b by=%b ovr=%0d, required 1/01/10/1",
               upd_valid, bounce_x, bounce_y, overrun_cnt);
    end
    upd_ready = 1'b1;
    cyc(1);
    vec_cnt++;
    if (upd_valid !== 1'b0 || overrun_cnt !== 8'd1) begin
      err_cnt++;
      $display("FAIL ovr_transfer: valid=%b ovr=%0d, required 0/1", upd_valid, overrun_cnt);
    end
  endtask

  task automatic test_simultaneous();
    upd_ready = 1'b1;
    pulse(4'b1100);
    col_y1 = 1'b1;
    boundary();
    col_y1 = 1'b0;
    vec_cnt++;
    if (upd_valid !== 1'b1 || bounce_x !== 2'b00 || bounce_y !== 2'b10) begin
      err_cnt++;
      $display("FAIL simul: valid=%b bx=%b by=%b, required 1/00/10", upd_valid, bounce_x, bounce_y);
    end
    cyc(1);
  endtask

  task automatic test_back_to_back();
    upd_ready = 1'b0;
    pulse(4'b1000);
    boundary();
    cyc(1);
    upd_ready = 1'b1;
    col_y2 = 1'b1;
    boundary();
    col_y2 = 1'b0;
    vec_cnt++;
    if (upd_valid !== 1'b1 || bounce_x !== 2'b00 || bounce_y !== 2'b01 || overrun_cnt !== 8'd1)
    begin
      err_cnt++;
      $display("FAIL b2b_reload: valid=%b bx=%b by=%b ovr=%0d, required 1/00/01/1",
               upd_valid, bounce_x, bounce_y, overrun_cnt);
    end
    cyc(1);
    vec_cnt++;
    if (upd_valid !== 1'b0) begin
      err_cnt++;
      $display("FAIL b2b_done: valid=%b, required 0", upd_valid);
    end
  endtask

  task automatic test_tick_enable();
    int ticks = 0;
    upd_ready = 1'b1;
    v_cnt = 10'd480; h_cnt = 10'd0;
    for (int i = 0; i < 4; i++) begin
      #1 if (frame_tick === 1'b1) ticks++;
      @(negedge clk);
    end
    h_cnt = 10'd1;
    vec_cnt++;
    if (ticks !== 1) begin
      err_cnt++;
      $display("FAIL tick_once: ticks=%0d, required 1", ticks);
    end
    cyc(2);
    enable = 1'b0;
    for (int f = 0; f < 3; f++) begin
      pulse(4'b1001);
      boundary();
      vec_cnt++;
      if (upd_valid !== 1'b0 || tick_seen !== 1'b1) begin
        err_cnt++;
        $display("FAIL disabled_frame%0d: valid=%b tick=%b, required 0/1", f, upd_valid,
                 tick_seen);
      end
      cyc(1);
    end
    enable = 1'b1;
  endtask

  initial begin
    rst = 1'b0;
    h_cnt = 10'd5; v_cnt = 10'd0;
    {col_x1, col_x2, col_y1, col_y2} = 4'b0000;
    enable = 1'b1; speed = 2'd0; upd_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_single();
    test_divider();
    test_overrun();
    test_simultaneous();
    test_back_to_back();
    test_tick_enable();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete, required completion");
    $fatal(1);
  end

endmodule
